frame_buf_scheduler: RTL and testbench
======================================

// Module: frame_buf_scheduler
// PURPOSE
//  Owns the single dual-port frame BRAM (port A write, port B read) and sequences one frame through it.
//  Phases: LOAD (grayscale camera fill) -> PROCESS (Sobel in-place read/write) -> DISPLAY (VGA read).
//  Multiplexes each port between requesters, converts (h,w) to linear addresses and starts the Sobel engine.
// PARAMETERS
//  IMG_W   640  frame width, pixels
//  IMG_H   480  frame height, lines
//  ADDR_W  19   BRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
//  DATA_W  8    pixel width
// PORTS
//  clk            in   1       system clock
//  reset_n        in   1       asynchronous, active-low reset
//  start          in   1       one-cycle pulse: begin a new frame
//  cam_valid      in   1       grayscale pixel strobe
//  cam_pixel      in   DATA_W  grayscale pixel
//  sobel_rd_h/w   in   16 each Sobel read coordinate
//  sobel_wr_valid in   1       Sobel result strobe
//  sobel_wr_h/w   in   16 each Sobel result coordinate
//  sobel_wr_data  in   DATA_W  Sobel result
//  sobel_done     in   1       Sobel engine finished the frame
//  vga_h/vga_w    in   16 each VGA scan coordinate
//  vga_active     in   1       VGA in visible area
//  bram_we        out  1       port A write enable
//  bram_waddr     out  ADDR_W  port A address
//  bram_wdata     out  DATA_W  port A data
//  bram_raddr     out  ADDR_W  port B address
//  sobel_start    out  1       one-cycle pulse on LOAD->PROCESS
//  phase          out  2       0 IDLE, 1 LOAD, 2 PROCESS, 3 DISPLAY
//  frame_loaded   out  1       high from LOAD completion until the next LOAD entry
//  err_oob        out  1       sticky: out-of-range write coordinate, or cam_valid outside LOAD
// BEHAVIOUR
//  Reset: phase=IDLE; all outputs 0; load counter 0; err_oob cleared. Reset mid-frame aborts immediately.
//  All outputs are registered. Address/we/data appear 1 cycle after the requesting inputs.
//  BRAM read data arrives 2 cycles after the coordinate is presented.
//  Address = h*IMG_W + w. IMG_W is constant (no general multiplier). Result truncated to ADDR_W.
//  IDLE: start -> LOAD. bram_we=0, bram_raddr holds 0.
//  LOAD:
//   - Entry clears the load counter (lc) and frame_loaded.
//   - Each cam_valid: we=1, waddr=lc, wdata=cam_pixel, lc++.
//   - The write with lc=IMG_W*IMG_H-1 is the last one; the next cycle is PROCESS, with sobel_start=1
//     and frame_loaded=1 for that cycle.
//   - Extra cam_valid strobes are never written.
//  PROCESS:
//   - raddr follows the Sobel read coordinate every cycle.
//   - sobel_wr_valid: we=1, waddr from the write coordinate, wdata=sobel_wr_data.
//   - sobel_done -> DISPLAY. A write and done in the same cycle: the write is still performed.
//  DISPLAY:
//   - bram_we=0.
//   - vga_active=1: raddr follows the VGA coordinate. vga_active=0: raddr holds its last value.
//   - start -> LOAD.
//  start is ignored in LOAD and PROCESS. start in the same cycle as sobel_done: done wins; start is dropped.
//  Any write with h>=IMG_H or w>=IMG_W: write suppressed (we=0), err_oob=1.
//  cam_valid in any phase other than LOAD: err_oob=1, nothing written.
//  err_oob clears only on reset.
// CONFIGURATION
//  FB_FRAME_LOOP_EN defined: DISPLAY->LOAD also fires automatically after the VGA read of
//   (IMG_H-1, IMG_W-1) with vga_active=1. This gives continuous video with no start pulse.
//  FB_FRAME_LOOP_EN undefined: DISPLAY persists until start; VGA coordinates never change phase.
// TESTING (bench with IMG_W=4, IMG_H=3)
//  1. Reset state: reset_n=0 mid-LOAD after 5 pixels -> phase=0, we=0, addresses 0. Re-start -> first write at waddr 0.
//  2. Full load: start, then 12 cam_valid with pixels 0x10..0x1B -> waddr 0..11 in order.
//     Cycle after the 12th write: sobel_start=1 for exactly 1 cycle, phase=2.
//  3. Sobel traffic: rd (2,3) -> raddr=11 one cycle later. wr_valid (1,2) data 0xAA -> we=1, waddr=6, wdata=0xAA.
//  4. Boundaries: wr (3,0) -> we=0, err_oob=1. wr_valid+sobel_done same cycle -> write performed, then phase=3.
//     cam_valid in PROCESS -> no write, err_oob stays 1.
//  5. Display: vga (1,1) active -> raddr=5. vga_active=0 -> raddr holds 5. start -> phase=1, frame_loaded=0.
//  6. FB_FRAME_LOOP_EN: VGA read of (2,3) active -> next cycle phase=1 without start.
//     Build without the macro: phase stays 3.

Source files
------------

// File: rtl/frame_buf_scheduler.sv
// ---------------------------------------------------------------------------
// frame_buf_scheduler
//   Owns the single dual-port frame BRAM (port A write, port B read) and walks
//   one frame through it: LOAD (camera fill) -> PROCESS (Sobel in-place
//   read/write) -> DISPLAY (VGA read). Each port is multiplexed between the
//   requesters of the current phase, and (h,w) coordinates are converted to
//   linear addresses (h*IMG_W + w, truncated to ADDR_W).
//
//   Ports
//     clk, reset_n                       clock, async active-low reset
//     start                              pulse: begin a new frame (IDLE/DISPLAY)
//     cam_valid, cam_pixel               grayscale camera stream (LOAD)
//     sobel_rd_h/w                       Sobel read coordinate (PROCESS)
//     sobel_wr_valid, sobel_wr_h/w/data  Sobel result write (PROCESS)
//     sobel_done                         Sobel engine finished -> DISPLAY
//     vga_h/w, vga_active                VGA scan coordinate (DISPLAY)
//     bram_we/waddr/wdata                port A, registered
//     bram_raddr                         port B address, registered
//     sobel_start                        one-cycle pulse on LOAD->PROCESS
//     phase                              0 IDLE, 1 LOAD, 2 PROCESS, 3 DISPLAY
//     frame_loaded                       frame complete, cleared on LOAD entry
//     err_oob                            sticky write/strobe error
//
//   Build option FB_FRAME_LOOP_EN: DISPLAY also returns to LOAD after the
//   active VGA read of the last pixel, giving free-running video.
// ---------------------------------------------------------------------------
module frame_buf_scheduler #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cam_valid,
  input  logic [DATA_W-1:0] cam_pixel,
  input  logic [15:0]       sobel_rd_h,
  input  logic [15:0]       sobel_rd_w,
  input  logic              sobel_wr_valid,
  input  logic [15:0]       sobel_wr_h,
  input  logic [15:0]       sobel_wr_w,
  input  logic [DATA_W-1:0] sobel_wr_data,
  input  logic              sobel_done,
  input  logic [15:0]       vga_h,
  input  logic [15:0]       vga_w,
  input  logic              vga_active,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_waddr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic [ADDR_W-1:0] bram_raddr,
  output logic              sobel_start,
  output logic [1:0]        phase,
  output logic              frame_loaded,
  output logic              err_oob
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PROC = 2'd2,
    S_DISP = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] lc_q, lc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              sstart_q, sstart_d;
  logic              floaded_q, floaded_d;
  logic              err_q, err_d;

  // Constant-width multiply by the IMG_W parameter; synthesis folds it into
  // shifts/adds. Working mod 2^ADDR_W throughout gives the truncated result.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [15:0] h,
                                                 input logic [15:0] w);
    return ADDR_W'(h) * ADDR_W'(IMG_W) + ADDR_W'(w);
  endfunction

  function automatic logic in_frame(input logic [15:0] h, input logic [15:0] w);
    return ({16'b0, h} < 32'(IMG_H)) && ({16'b0, w} < 32'(IMG_W));
  endfunction

  always_comb begin
    state_d   = state_q;
    lc_d      = lc_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    raddr_d   = raddr_q;
    sstart_d  = 1'b0;
    floaded_d = floaded_q;
    err_d     = err_q;

    // Camera strobes are only legal while filling the frame.
    if (cam_valid && state_q != S_LOAD) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        raddr_d = '0;
        if (start) begin
          state_d   = S_LOAD;
          lc_d      = '0;
          floaded_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (cam_valid) begin
          we_d    = 1'b1;
          waddr_d = lc_q;
          wdata_d = cam_pixel;
          lc_d    = lc_q + ADDR_W'(1);
          if (lc_q == LAST_PIX) begin
            state_d   = S_PROC;
            sstart_d  = 1'b1;
            floaded_d = 1'b1;
          end
        end
      end
      S_PROC: begin
        raddr_d = lin_addr(sobel_rd_h, sobel_rd_w);
        if (sobel_wr_valid) begin
          if (in_frame(sobel_wr_h, sobel_wr_w)) begin
            we_d    = 1'b1;
            waddr_d = lin_addr(sobel_wr_h, sobel_wr_w);
            wdata_d = sobel_wr_data;
          end else begin
            err_d = 1'b1;
          end
        end
        // start is not looked at here, so a start coincident with done is lost.
        if (sobel_done) state_d = S_DISP;
      end
      S_DISP: begin
        if (vga_active) raddr_d = lin_addr(vga_h, vga_w);
        if (start) begin
          state_d   = S_LOAD;
          lc_d      = '0;
          floaded_d = 1'b0;
        end
`ifdef FB_FRAME_LOOP_EN
        else if (vga_active && vga_h == 16'(IMG_H - 1) && vga_w == 16'(IMG_W - 1)) begin
          state_d   = S_LOAD;
          lc_d      = '0;
          floaded_d = 1'b0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      lc_q      <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_q   <= '0;
      sstart_q  <= 1'b0;
      floaded_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lc_q      <= lc_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      raddr_q   <= raddr_d;
      sstart_q  <= sstart_d;
      floaded_q <= floaded_d;
      err_q     <= err_d;
    end
  end

  assign bram_we      = we_q;
  assign bram_waddr   = waddr_q;
  assign bram_wdata   = wdata_q;
  assign bram_raddr   = raddr_q;
  assign sobel_start  = sstart_q;
  assign phase        = state_q;
  assign frame_loaded = floaded_q;
  assign err_oob      = err_q;

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_buf_scheduler
//   Table-driven bench for frame_buf_scheduler with a 4x3 frame. Each record
//   holds one cycle of inputs and the registered outputs expected after the
//   following rising edge; expectations go through a scoreboard queue.
//   Asynchronous reset mid-LOAD is a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_frame_buf_scheduler;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int DW = 8;
`ifdef FB_FRAME_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, cam_valid, sobel_wr_valid, sobel_done, vga_active;
  logic [DW-1:0] cam_pixel, sobel_wr_data;
  logic [15:0]   sobel_rd_h, sobel_rd_w, sobel_wr_h, sobel_wr_w, vga_h, vga_w;
  logic          bram_we, sobel_start, frame_loaded, err_oob;
  logic [AW-1:0] bram_waddr, bram_raddr;
  logic [DW-1:0] bram_wdata;
  logic [1:0]    phase;

  int checks   = 0;
  int failures = 0;
  int vidx     = 0;

  frame_buf_scheduler #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cam_valid(cam_valid), .cam_pixel(cam_pixel),
    .sobel_rd_h(sobel_rd_h), .sobel_rd_w(sobel_rd_w),
    .sobel_wr_valid(sobel_wr_valid), .sobel_wr_h(sobel_wr_h),
    .sobel_wr_w(sobel_wr_w), .sobel_wr_data(sobel_wr_data),
    .sobel_done(sobel_done),
    .vga_h(vga_h), .vga_w(vga_w), .vga_active(vga_active),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
    .bram_raddr(bram_raddr), .sobel_start(sobel_start), .phase(phase),
    .frame_loaded(frame_loaded), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          start;
    logic          cam_v;
    logic [7:0]    pix;
    logic [15:0]   rh, rw;
    logic          wv;
    logic [15:0]   wh, ww;
    logic [7:0]    wd;
    logic          done;
    logic [15:0]   vh, vw;
    logic          va;
    logic          e_we;
    logic [AW-1:0] e_wa;
    logic [7:0]    e_wd;
    logic          cr;      // compare raddr (unspecified while loading)
    logic [AW-1:0] e_ra;
    logic [1:0]    e_ph;
    logic          e_ss, e_fl, e_err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t nop();
    vec_t v = '0;
    return v;
  endfunction
  function automatic vec_t st();
    vec_t v = '0;
    v.start = 1'b1;
    return v;
  endfunction
  function automatic vec_t cam(input logic [7:0] p);
    vec_t v = '0;
    v.cam_v = 1'b1; v.pix = p;
    return v;
  endfunction
  function automatic vec_t sob(input logic [15:0] rh, input logic [15:0] rw,
                               input logic wv, input logic [15:0] wh,
                               input logic [15:0] ww, input logic [7:0] wd,
                               input logic dn, input logic s);
    vec_t v = '0;
    v.rh = rh; v.rw = rw; v.wv = wv; v.wh = wh; v.ww = ww; v.wd = wd;
    v.done = dn; v.start = s;
    return v;
  endfunction
  function automatic vec_t vga(input logic [15:0] h, input logic [15:0] w,
                               input logic a);
    vec_t v = '0;
    v.vh = h; v.vw = w; v.va = a;
    return v;
  endfunction
  function automatic vec_t ex(input vec_t vi, input logic we, input logic [AW-1:0] wa,
                              input logic [7:0] wd, input logic cr,
                              input logic [AW-1:0] ra, input logic [1:0] ph,
                              input logic ss, input logic fl, input logic er);
    vec_t v = vi;
    v.e_we = we; v.e_wa = wa; v.e_wd = wd; v.cr = cr; v.e_ra = ra;
    v.e_ph = ph; v.e_ss = ss; v.e_fl = fl; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    start = v.start; cam_valid = v.cam_v; cam_pixel = v.pix;
    sobel_rd_h = v.rh; sobel_rd_w = v.rw;
    sobel_wr_valid = v.wv; sobel_wr_h = v.wh; sobel_wr_w = v.ww;
    sobel_wr_data = v.wd; sobel_done = v.done;
    vga_h = v.vh; vga_w = v.vw; vga_active = v.va;
  endtask

  task automatic check_out();
    vec_t e;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL v%0d scoreboard: got empty queue expected an entry", vidx);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d phase", vidx), 32'(phase), 32'(e.e_ph));
    chk($sformatf("v%0d we", vidx), 32'(bram_we), 32'(e.e_we));
    if (e.e_we) begin
      chk($sformatf("v%0d waddr", vidx), 32'(bram_waddr), 32'(e.e_wa));
      chk($sformatf("v%0d wdata", vidx), 32'(bram_wdata), 32'(e.e_wd));
    end
    if (e.cr) chk($sformatf("v%0d raddr", vidx), 32'(bram_raddr), 32'(e.e_ra));
    chk($sformatf("v%0d sobel_start", vidx), 32'(sobel_start), 32'(e.e_ss));
    chk($sformatf("v%0d frame_loaded", vidx), 32'(frame_loaded), 32'(e.e_fl));
    chk($sformatf("v%0d err_oob", vidx), 32'(err_oob), 32'(e.e_err));
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      check_out();
      vidx++;
    end
    tbl.delete();
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b0;
    drive(nop());
    repeat (2) @(posedge clk);
    #1;
    chk("reset phase", 32'(phase), 32'd0);
    chk("reset we", 32'(bram_we), 32'd0);
    chk("reset raddr", 32'(bram_raddr), 32'd0);
    chk("reset err_oob", 32'(err_oob), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // cam strobe in IDLE flags an error; then a partial load to be aborted.
    tbl.push_back(ex(cam(8'h01), 1'b0, 4'd0, 8'd0, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(ex(st(), 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(ex(cam(8'(8'h10 + i)), 1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 4'd0,
                       2'd1, 1'b0, 1'b0, 1'b1));
    run_table();

    // Asynchronous reset in the middle of LOAD: outputs clear with no clock edge.
    @(negedge clk);
    drive(nop());
    reset_n = 1'b0;
    #1;
    chk("midload reset phase", 32'(phase), 32'd0);
    chk("midload reset we", 32'(bram_we), 32'd0);
    chk("midload reset waddr", 32'(bram_waddr), 32'd0);
    chk("midload reset raddr", 32'(bram_raddr), 32'd0);
    chk("midload reset err_oob", 32'(err_oob), 32'd0);
    chk("midload reset frame_loaded", 32'(frame_loaded), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full frame load; a start mid-load is ignored.
    tbl.push_back(ex(st(), 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < W * H; i++) begin
      v = cam(8'(8'h10 + i));
      if (i == 5) v.start = 1'b1;
      tbl.push_back(ex(v, 1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 4'd0,
                       (i == W * H - 1) ? 2'd2 : 2'd1, i == W * H - 1, i == W * H - 1, 1'b0));
    end
    // PROCESS: sobel_start gone, read/write traffic, boundaries.
    tbl.push_back(ex(sob(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 4'd0, 8'd0, 1'b1, 4'd0, 2'd2, 1'b0, 1'b1, 1'b0));
    tbl.push_back(ex(sob(2, 3, 0, 0, 0, 0, 0, 0), 1'b0, 4'd0, 8'd0, 1'b1, 4'd11, 2'd2, 1'b0, 1'b1, 1'b0));
    tbl.push_back(ex(sob(0, 1, 1, 1, 2, 8'hAA, 0, 0), 1'b1, 4'd6, 8'hAA, 1'b1, 4'd1, 2'd2, 1'b0, 1'b1, 1'b0));
    tbl.push_back(ex(sob(0, 1, 1, 3, 0, 8'h55, 0, 0), 1'b0, 4'd0, 8'd0, 1'b1, 4'd1, 2'd2, 1'b0, 1'b1, 1'b1));
    tbl.push_back(ex(sob(0, 0, 1, 0, 4, 8'h55, 0, 0), 1'b0, 4'd0, 8'd0, 1'b1, 4'd0, 2'd2, 1'b0, 1'b1, 1'b1));
    v = sob(0, 0, 0, 0, 0, 0, 0, 0);
    v.cam_v = 1'b1; v.pix = 8'h99;
    tbl.push_back(ex(v, 1'b0, 4'd0, 8'd0, 1'b1, 4'd0, 2'd2, 1'b0, 1'b1, 1'b1));
    // Write + done + start together: write lands, DISPLAY entered, start lost.
    tbl.push_back(ex(sob(1, 0, 1, 2, 3, 8'h77, 1, 1), 1'b1, 4'd11, 8'h77, 1'b1, 4'd4, 2'd3, 1'b0, 1'b1, 1'b1));
    // DISPLAY
    tbl.push_back(ex(vga(0, 0, 0), 1'b0, 4'd0, 8'd0, 1'b1, 4'd4, 2'd3, 1'b0, 1'b1, 1'b1));
    tbl.push_back(ex(vga(1, 1, 1), 1'b0, 4'd0, 8'd0, 1'b1, 4'd5, 2'd3, 1'b0, 1'b1, 1'b1));
    tbl.push_back(ex(vga(2, 2, 0), 1'b0, 4'd0, 8'd0, 1'b1, 4'd5, 2'd3, 1'b0, 1'b1, 1'b1));
    tbl.push_back(ex(vga(2, 3, 1), 1'b0, 4'd0, 8'd0, 1'b1, 4'd11,
                     LOOP ? 2'd1 : 2'd3, 1'b0, !LOOP, 1'b1));
    tbl.push_back(ex(vga(0, 0, 0), 1'b0, 4'd0, 8'd0, !LOOP, 4'd11,
                     LOOP ? 2'd1 : 2'd3, 1'b0, !LOOP, 1'b1));
    tbl.push_back(ex(st(), 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(ex(cam(8'h42), 1'b1, 4'd0, 8'h42, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b1));
    run_table();

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
